// File: rtl/load_store_unit_if.sv
// Byte-wide data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte/word accesses as 1 or 4 byte beats.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned word accesses.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 16,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  word,
    output logic [31:0]           read_data,
    output logic                  stall,
    output logic                  err,
    load_store_unit_if.master     mem
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t                state;
    logic [1:0]            beat;
    logic [1:0]            beat_nxt;
    logic [1:0]            last;
    logic [TW-1:0]         timer;
    logic                  we;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [31:0]           asm_q;
    logic [31:0]           asm_nxt;
    logic                  req_in;
    logic                  trap;

    assign req_in   = memRead | memWrite;
    assign beat_nxt = beat + 2'd1;
    assign stall    = !reset &&
                      ((state == REQ) || (state == IDLE && req_in));

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = word && (address[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // Read assembly including the byte arriving this cycle.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{beat, 3'b000} +: 8] = mem.mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= 2'd0;
            last          <= 2'd0;
            timer         <= '0;
            we            <= 1'b0;
            base          <= '0;
            wdata         <= 32'd0;
            asm_q         <= 32'd0;
            read_data     <= 32'd0;
            err           <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= 8'd0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_in) begin
                        if (trap) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end else begin
                            state         <= REQ;
                            base          <= address;
                            wdata         <= write_data;
                            we            <= memWrite;
                            last          <= word ? 2'd3 : 2'd0;
                            beat          <= 2'd0;
                            timer         <= '0;
                            asm_q         <= 32'd0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= memWrite;
                            mem.mem_addr  <= address;
                            mem.mem_wdata <= write_data[7:0];
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        if (!we) asm_q <= asm_nxt;
                        if (beat == last) begin
                            state       <= DONE;
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                            if (!we) read_data <= asm_nxt;
                        end else begin
                            beat          <= beat_nxt;
                            timer         <= '0;
                            mem.mem_addr  <= base + ADDR_WIDTH'(beat_nxt);
                            mem.mem_wdata <= wdata[{beat_nxt, 3'b000} +: 8];
                        end
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        // Memory never answered: abort, keep read_data.
                        state       <= DONE;
                        err         <= 1'b1;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
